control_unit: RTL
=================

# control_unit

Microcoded control sequencer for the 8-bit CPU: drives the per-cycle control word (bus enables, register loads, ALU subtract, flag load, program-counter control, halt) from a 3-bit step counter, the instruction register's opcode nibble, and the ALU's registered carry/zero flags. It consumes the flags the ALU produces and sources the `subtract` and `flags_in` strobes the ALU consumes. All datapath registers latch on the same rising edge that advances the step counter.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `opcode`  in  4  instruction register bits [7:4]; valid from step T2 onward.
- `carry`  in  1  ALU registered carry flag.
- `zero`  in  1  ALU registered zero flag.
- `hlt`  out  1  halt clock/activity indicator.
- `mi`, `ri`, `ro`  out  1 each  memory-address-register load, RAM write, RAM drive bus.
- `io`, `ii`  out  1 each  IR low nibble drive bus, IR load.
- `ai`, `ao`  out  1 each  A register load, A drive bus.
- `eo`, `su`, `fi`  out  1 each  ALU drive bus, ALU subtract, ALU flag load (`flags_in`).
- `bi`, `oi`  out  1 each  B register load, output register load.
- `ce`, `co`, `j`  out  1 each  PC increment, PC drive bus, PC load from bus.
- `step`  out  3  current microstep (debug).

## Operation
- State: `step` register (0..4) and `halted` bit.
- Control word is combinational from `step`, `opcode`, `carry`, `zero`, `halted`; all bits 0 while `rst`=1 and in any step not listed.
- Fetch (all opcodes): T0 `co|mi`; T1 `ro|ii|ce`.
- Execute (decoded at T2; last listed step is final):
  - 0x0 NOP: T2 none.
  - 0x1 LDA: T2 `io|mi`; T3 `ro|ai`.
  - 0x2 ADD: T2 `io|mi`; T3 `ro|bi`; T4 `eo|ai|fi`.
  - 0x3 SUB: as ADD, T4 adds `su`.
  - 0x4 STA: T2 `io|mi`; T3 `ao|ri`.
  - 0x5 LDI: T2 `io|ai`.
  - 0x6 JMP: T2 `io|j`.
  - 0x7 JC: T2 `io|j` if `carry`=1, else none.
  - 0x8 JZ: T2 `io|j` if `zero`=1, else none.
  - 0xE OUT: T2 `ao|oi`.
  - 0xF HLT: T2 `hlt`; sets `halted`.
  - 0x9–0xD: treated as NOP.
- Step advance: at rising edge, if final step then `step`←0, else `step`←`step`+1. Variable length, no padding cycles.
- `halted`=1: `step` frozen, `hlt`=1, all other outputs 0; exit only via `rst`.
- `su` asserted only in SUB T4; `fi` only in ADD/SUB T4. No other step may load flags.

## Timing
- Reset: edge with `rst`=1 forces `step`=0, `halted`=0, regardless of current step or halt. While `rst`=1 all outputs 0, `step` output shows 0 after the first reset edge. First cycle after release is T0: `co`=`mi`=1.
- Instruction lengths in cycles: NOP/LDI/JMP/JC/JZ/OUT/undefined 3; LDA/STA 4; ADD/SUB 5; HLT 3 then halt indefinitely.
- Flags sampled combinationally during JC/JZ T2. Flags written by ADD/SUB T4 edge are visible to an immediately following JC/JZ, whose T2 is two cycles later.
- `opcode` ignored in T0/T1. It may change at the T1→T2 edge without glitching decode.
- Reset mid-instruction: partial instruction is abandoned. No further control bits from it after the reset edge.

## Test plan
- Reset, release: `step`=0, outputs exactly `co`=`mi`=1. Next cycle `ro`=`ii`=`ce`=1. Assert `rst` at T3 of ADD: next cycle all zero, then T0.
- Opcode 0x2 stream: T2 `io|mi`, T3 `ro|bi`, T4 `eo|ai|fi` with `su`=0, then T0 on 6th cycle. Opcode 0x3: identical except `su`=1 in T4 only.
- Opcode 0x7 with `carry`=0: T2 all zero, 3 cycles. With `carry`=1: T2 `io|j`. Repeat 0x8 with `zero`.
- Opcode 0xF: T2 `hlt`=1. For 20 further cycles `hlt`=1, `step`=2, all else 0, even if `opcode` changes. `rst` pulse returns to T0.
- Opcodes 0x9–0xD and 0x0: 3-cycle instruction, T2 control word all zero.
- Program sequence LDA, ADD, STA, OUT, JMP: instruction boundaries land at cycles 0, 4, 9, 13, 16, 19; the control word matches the table every cycle.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: microcoded step sequencer producing the per-cycle control word
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry,
  input  logic       zero,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       io,
  output logic       ii,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       fi,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j,
  output logic [2:0] step
);
  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO = 16'h0080, SU = 16'h0040, FI = 16'h0020, BI = 16'h0010;
  localparam logic [15:0] OI = 16'h0008, CE = 16'h0004, CO = 16'h0002, J  = 16'h0001;
  logic [15:0] cw, word;
  logic        last, halted;
  always_comb begin
    word = '0;
    last = 1'b1;
    case (step)
      3'd0: begin word = CO | MI; last = 1'b0; end
      3'd1: begin word = RO | II | CE; last = 1'b0; end
      3'd2: begin
        last = !(opcode inside {4'h1, 4'h2, 4'h3, 4'h4});
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4: word = IO | MI;
          4'h5: word = IO | AI;
          4'h6: word = IO | J;
          4'h7: word = carry ? IO | J : '0;
          4'h8: word = zero ? IO | J : '0;
          4'he: word = AO | OI;
          4'hf: word = HLT;
          default: word = '0;
        endcase
      end
      3'd3: begin
        last = !(opcode inside {4'h2, 4'h3});
        word = opcode == 4'h1 ? RO | AI :
               opcode == 4'h4 ? AO | RI :
               opcode inside {4'h2, 4'h3} ? RO | BI : '0;
      end
      3'd4: word = opcode inside {4'h2, 4'h3} ? (EO | AI | FI | (opcode[0] ? SU : '0)) : '0;
      default: word = '0;
    endcase
    cw = rst ? '0 : halted ? HLT : word;
  end
  assign {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, fi, bi, oi, ce, co, j} = cw;
  // HLT parks the sequencer at T2 so the debug step stays visible while halted
  always_ff @(posedge clk) begin
    if (rst) begin
      step   <= 3'd0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (step == 3'd2 && opcode == 4'hf) halted <= 1'b1;
      else step <= last ? 3'd0 : step + 3'd1;
    end
  end
endmodule
